breakout_game_ctrl: RTL and testbench



---
 rtl/breakout_pkg.sv | 17 +
 rtl/bcd_counter4.sv | 49 ++++
 rtl/breakout_game_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared types and constants for the Breakout game-flow controller.
//   state_e            : controller states (2-bit, encoding visible on the state port)
//   KEY_START_DEFAULT  : keypad code that starts a game / launches a ball
//   BCD_DIGIT_MAX      : largest value a single BCD digit may hold
package breakout_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_e;

  localparam logic [4:0] KEY_START_DEFAULT = 5'h10;
  localparam logic [3:0] BCD_DIGIT_MAX     = 4'd9;

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit packed BCD up-counter, saturating at 9999.
//   clk   : clock
//   rstn  : asynchronous active-low reset (value -> 0)
//   clr   : synchronous clear (has priority over inc)
//   inc   : increment by one when not already at 9999
//   value : registered 16-bit packed BCD count
module bcd_counter4
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;
  logic        carry;

  always_comb begin
    value_d = value_q;
    carry   = 1'b0;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != 16'h9999)) begin
      // Ripple the +1 through the digits; a digit at 9 rolls to 0 and
      // passes the carry on, the first digit below 9 absorbs it.
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (value_q[i*4 +: 4] == BCD_DIGIT_MAX) begin
            value_d[i*4 +: 4] = 4'd0;
          end else begin
            value_d[i*4 +: 4] = value_q[i*4 +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: Breakout game-flow controller (newgame/play/newball/over).
//   clk, rstn   : clock, asynchronous active-low reset
//   key_code    : keypad code, qualified by key_ready (level)
//   hit, miss   : ball events from the graphics stage (level or pulse)
//   gra_still   : freezes ball/paddle motion outside play
//   state       : 00 newgame, 01 play, 10 newball, 11 over
//   balls_left  : remaining balls
//   score_bcd   : 4-digit BCD score
//   seg_data    : registered {hiscore_bcd, score_bcd} for the 7-seg driver
//   hiscore_bcd : best score; only tracked when BREAKOUT_HISCORE_EN is defined,
//                 otherwise tied to 0
// Inputs are edge-detected into registered events, so an input rising edge
// shows up on the outputs two clocks later.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned BALLS        = 3,
  parameter int unsigned DELAY_CYCLES = 100_000_000,
  parameter logic [4:0]  KEY_START    = KEY_START_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  key_code,
  input  logic        key_ready,
  input  logic        hit,
  input  logic        miss,
  output logic        gra_still,
  output logic [1:0]  state,
  output logic [2:0]  balls_left,
  output logic [15:0] score_bcd,
  output logic [31:0] seg_data,
  output logic [15:0] hiscore_bcd
);

  localparam int unsigned TW         = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(DELAY_CYCLES - 1);
  localparam logic [2:0]  BALLS_INIT = 3'(BALLS);

  // Edge detectors
  logic key_ready_q, hit_q, miss_q;
  logic key_press_q, key_press_d;
  logic hit_ev_q, hit_ev_d;
  logic miss_ev_q, miss_ev_d;

  assign key_press_d = key_ready & ~key_ready_q & (key_code == KEY_START);
  assign hit_ev_d    = hit & ~hit_q;
  assign miss_ev_d   = miss & ~miss_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_ready_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      key_press_q <= 1'b0;
      hit_ev_q    <= 1'b0;
      miss_ev_q   <= 1'b0;
    end else begin
      key_ready_q <= key_ready;
      hit_q       <= hit;
      miss_q      <= miss;
      key_press_q <= key_press_d;
      hit_ev_q    <= hit_ev_d;
      miss_ev_q   <= miss_ev_d;
    end
  end

  // Controller FSM
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    balls_q, balls_d;
  logic          gra_still_q, gra_still_d;
  logic          score_inc, score_clr;
  logic [15:0]   score;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    balls_d   = balls_q;
    score_inc = 1'b0;
    unique case (state_q)
      NEWGAME: begin
        balls_d = BALLS_INIT;
        if (key_press_q) state_d = PLAY;
      end
      PLAY: begin
        score_inc = hit_ev_q;
        if (miss_ev_q) begin
          balls_d = balls_q - 3'd1;
          timer_d = TIMER_LOAD;
          state_d = (balls_q == 3'd1) ? OVER : NEWBALL;
        end
      end
      NEWBALL: begin
        if (timer_q != '0)    timer_d = timer_q - TW'(1);
        else if (key_press_q) state_d = PLAY;
      end
      OVER: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = NEWGAME;
          balls_d = BALLS_INIT;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Score is held at zero for as long as the next state is newgame, which
  // also covers the clear on the over -> newgame transition.
  assign score_clr   = (state_d == NEWGAME);
  assign gra_still_d = (state_d != PLAY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= NEWGAME;
      timer_q     <= '0;
      balls_q     <= BALLS_INIT;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      balls_q     <= balls_d;
      gra_still_q <= gra_still_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score)
  );

  // High score
  logic [15:0] hiscore;

`ifdef BREAKOUT_HISCORE_EN
  logic        over_entry_q, over_entry_d;
  logic [15:0] hiscore_q, hiscore_d;

  // The compare is done the cycle after entering over so that a hit landing
  // together with the final miss is already reflected in the score.
  assign over_entry_d = (state_d == OVER) && (state_q != OVER);

  always_comb begin
    hiscore_d = hiscore_q;
    if (over_entry_q && (score > hiscore_q)) hiscore_d = score;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      over_entry_q <= 1'b0;
      hiscore_q    <= '0;
    end else begin
      over_entry_q <= over_entry_d;
      hiscore_q    <= hiscore_d;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  // 7-seg data
  logic [31:0] seg_data_q, seg_data_d;

  assign seg_data_d = {hiscore, score};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) seg_data_q <= '0;
    else       seg_data_q <= seg_data_d;
  end

  assign gra_still   = gra_still_q;
  assign state       = state_q;
  assign balls_left  = balls_q;
  assign score_bcd   = score;
  assign seg_data    = seg_data_q;
  assign hiscore_bcd = hiscore;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: directed self-checking bench for breakout_game_ctrl
// (BALLS=3, DELAY_CYCLES=16, KEY_START=5'h10). Expected high score depends on
// whether BREAKOUT_HISCORE_EN is defined for the build.
module tb_breakout_game_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_ready = 1'b0;
  logic        hit = 1'b0;
  logic        miss = 1'b0;
  logic        gra_still;
  logic [1:0]  state;
  logic [2:0]  balls_left;
  logic [15:0] score_bcd;
  logic [31:0] seg_data;
  logic [15:0] hiscore_bcd;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

`ifdef BREAKOUT_HISCORE_EN
  localparam logic [15:0] EXP_HI = 16'h9999;
`else
  localparam logic [15:0] EXP_HI = 16'h0000;
`endif

  breakout_game_ctrl #(
    .BALLS        (3),
    .DELAY_CYCLES (16),
    .KEY_START    (5'h10)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .hit         (hit),
    .miss        (miss),
    .gra_still   (gra_still),
    .state       (state),
    .balls_left  (balls_left),
    .score_bcd   (score_bcd),
    .seg_data    (seg_data),
    .hiscore_bcd (hiscore_bcd)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_key(input logic [4:0] code);
    key_code = code; key_ready = 1'b1; tick();
    key_ready = 1'b0; tick();
  endtask

  task automatic pulse_hit();
    hit = 1'b1; tick();
    hit = 1'b0; tick();
  endtask

  task automatic pulse_miss();
    miss = 1'b1; tick();
    miss = 1'b0; tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL reset_state got=%b exp=00", state); end
    vectors++; if (gra_still !== 1'b1) begin miscompares++; $display("FAIL reset_still got=%b exp=1", gra_still); end
    vectors++; if (balls_left !== 3'd3) begin miscompares++; $display("FAIL reset_balls got=%0d exp=3", balls_left); end
    vectors++; if (score_bcd !== 16'h0) begin miscompares++; $display("FAIL reset_score got=%h exp=0000", score_bcd); end
    vectors++; if (seg_data !== 32'h0) begin miscompares++; $display("FAIL reset_seg got=%h exp=00000000", seg_data); end
    vectors++; if (hiscore_bcd !== 16'h0) begin miscompares++; $display("FAIL reset_hiscore got=%h exp=0000", hiscore_bcd); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_start();
    pulse_key(5'h03);
    tick();
    vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL wrong_key got=%b exp=00", state); end
    key_code = 5'h10; key_ready = 1'b1; tick();
    vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL start_latency got=%b exp=00", state); end
    key_ready = 1'b0; tick();
    vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL start_state got=%b exp=01", state); end
    vectors++; if (gra_still !== 1'b0) begin miscompares++; $display("FAIL start_still got=%b exp=0", gra_still); end
    vectors++; if (balls_left !== 3'd3) begin miscompares++; $display("FAIL start_balls got=%0d exp=3", balls_left); end
    vectors++; if (score_bcd !== 16'h0) begin miscompares++; $display("FAIL start_score got=%h exp=0000", score_bcd); end
  endtask

  task automatic test_hits();
    repeat (12) pulse_hit();
    tick();
    vectors++; if (score_bcd !== 16'h0012) begin miscompares++; $display("FAIL hits12_score got=%h exp=0012", score_bcd); end
    vectors++; if (seg_data[15:0] !== 16'h0012) begin miscompares++; $display("FAIL hits12_seg got=%h exp=0012", seg_data[15:0]); end
    hit = 1'b1;
    repeat (5) tick();
    hit = 1'b0;
    repeat (2) tick();
    vectors++; if (score_bcd !== 16'h0013) begin miscompares++; $display("FAIL hit_held got=%h exp=0013", score_bcd); end
  endtask

  task automatic test_saturation();
    repeat (9998 - 13) pulse_hit();
    vectors++; if (score_bcd !== 16'h9998) begin miscompares++; $display("FAIL preload_9998 got=%h exp=9998", score_bcd); end
    pulse_hit();
    vectors++; if (score_bcd !== 16'h9999) begin miscompares++; $display("FAIL reach_9999 got=%h exp=9999", score_bcd); end
    repeat (2) pulse_hit();
    tick();
    vectors++; if (score_bcd !== 16'h9999) begin miscompares++; $display("FAIL saturate got=%h exp=9999", score_bcd); end
    vectors++; if (seg_data[15:0] !== 16'h9999) begin miscompares++; $display("FAIL saturate_seg got=%h exp=9999", seg_data[15:0]); end
  endtask

  task automatic test_newball();
    pulse_miss();
    vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL miss_state got=%b exp=10", state); end
    vectors++; if (balls_left !== 3'd2) begin miscompares++; $display("FAIL miss_balls got=%0d exp=2", balls_left); end
    vectors++; if (gra_still !== 1'b1) begin miscompares++; $display("FAIL newball_still got=%b exp=1", gra_still); end
    tick(); tick(); tick();
    pulse_key(5'h10);
    vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL early_key got=%b exp=10", state); end
    pulse_miss();
    vectors++; if (balls_left !== 3'd2) begin miscompares++; $display("FAIL newball_miss got=%0d exp=2", balls_left); end
    repeat (20) tick();
    vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL newball_wait got=%b exp=10", state); end
    pulse_key(5'h10);
    vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL relaunch got=%b exp=01", state); end
    vectors++; if (score_bcd !== 16'h9999) begin miscompares++; $display("FAIL relaunch_score got=%h exp=9999", score_bcd); end
  endtask

  task automatic test_game_over();
    pulse_miss();
    repeat (20) tick();
    pulse_key(5'h10);
    vectors++; if (balls_left !== 3'd1) begin miscompares++; $display("FAIL balls_one got=%0d exp=1", balls_left); end
    pulse_miss();
    vectors++; if (state !== 2'b11) begin miscompares++; $display("FAIL over_state got=%b exp=11", state); end
    vectors++; if (balls_left !== 3'd0) begin miscompares++; $display("FAIL over_balls got=%0d exp=0", balls_left); end
    pulse_key(5'h10);
    repeat (13) tick();
    vectors++; if (state !== 2'b11) begin miscompares++; $display("FAIL over_hold got=%b exp=11", state); end
    vectors++; if (score_bcd !== 16'h9999) begin miscompares++; $display("FAIL over_score got=%h exp=9999", score_bcd); end
    tick();
    vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL over_exit got=%b exp=00", state); end
    vectors++; if (balls_left !== 3'd3) begin miscompares++; $display("FAIL newgame_balls got=%0d exp=3", balls_left); end
    vectors++; if (score_bcd !== 16'h0) begin miscompares++; $display("FAIL newgame_score got=%h exp=0000", score_bcd); end
    vectors++; if (hiscore_bcd !== EXP_HI) begin miscompares++; $display("FAIL hiscore got=%h exp=%h", hiscore_bcd, EXP_HI); end
    tick();
    vectors++; if (seg_data !== {EXP_HI, 16'h0}) begin miscompares++; $display("FAIL newgame_seg got=%h exp=%h", seg_data, {EXP_HI, 16'h0}); end
  endtask

  task automatic test_same_cycle();
    pulse_key(5'h10);
    pulse_miss(); repeat (20) tick(); pulse_key(5'h10);
    pulse_miss(); repeat (20) tick(); pulse_key(5'h10);
    vectors++; if (balls_left !== 3'd1) begin miscompares++; $display("FAIL last_ball got=%0d exp=1", balls_left); end
    hit = 1'b1; miss = 1'b1; tick();
    hit = 1'b0; miss = 1'b0; tick();
    vectors++; if (state !== 2'b11) begin miscompares++; $display("FAIL same_cycle_state got=%b exp=11", state); end
    vectors++; if (score_bcd !== 16'h0001) begin miscompares++; $display("FAIL same_cycle_score got=%h exp=0001", score_bcd); end
    repeat (2) tick();
    vectors++; if (hiscore_bcd !== EXP_HI) begin miscompares++; $display("FAIL hiscore_kept got=%h exp=%h", hiscore_bcd, EXP_HI); end
  endtask

  task automatic test_async_reset();
    repeat (20) tick();
    pulse_key(5'h10);
    pulse_hit(); pulse_hit();
    vectors++; if (score_bcd !== 16'h0002) begin miscompares++; $display("FAIL pre_reset_score got=%h exp=0002", score_bcd); end
    #2 rstn = 1'b0;
    #1;
    vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL async_state got=%b exp=00", state); end
    vectors++; if (gra_still !== 1'b1) begin miscompares++; $display("FAIL async_still got=%b exp=1", gra_still); end
    vectors++; if (score_bcd !== 16'h0) begin miscompares++; $display("FAIL async_score got=%h exp=0000", score_bcd); end
    vectors++; if (hiscore_bcd !== 16'h0) begin miscompares++; $display("FAIL async_hiscore got=%h exp=0000", hiscore_bcd); end
    vectors++; if (seg_data !== 32'h0) begin miscompares++; $display("FAIL async_seg got=%h exp=00000000", seg_data); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_hits();
    test_saturation();
    test_newball();
    test_game_over();
    test_same_cycle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
